alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 151 +++++++++++++++
 tb/tb_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit MIPS-style ALU with a one-cycle registered result and flags
// Shift operations are built only when ALU_SHIFT_EN is defined; otherwise their funct codes decode as unrecognised.
module alu (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] regA,
   input  logic [31:0] regB,
   output logic [31:0] result,
   output logic [2:0]  flags
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_SLTU = 6'b101011;
`ifdef ALU_SHIFT_EN
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_SLLV = 6'b000100;
   localparam logic [5:0] F_SRLV = 6'b000110;
   localparam logic [5:0] F_SRAV = 6'b000111;
`endif

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [31:0] imm_sx;
   logic [31:0] imm_zx;

   assign opcode = instruction[31:26];
   assign funct  = instruction[5:0];
   assign imm    = instruction[15:0];
   assign imm_sx = {{16{imm[15]}}, imm};
   assign imm_zx = {16'h0000, imm};

   // Register-number fields are resolved upstream; shamt is only consumed by shift builds.
   logic unused_fields;
   assign unused_fields = ^instruction[25:6];

   logic [31:0] add_rr;
   logic [31:0] add_ri;
   logic [31:0] sub_rr;
   logic        add_ovf;
   logic        addi_ovf;
   logic        sub_ovf;
   logic        slt_rr;
   logic        sltu_rr;
   logic        slt_ri;
   logic        sltu_ri;

   assign add_rr   = regA + regB;
   assign add_ri   = regA + imm_sx;
   assign sub_rr   = regA - regB;
   assign add_ovf  = (regA[31] == regB[31])   && (add_rr[31] != regA[31]);
   assign addi_ovf = (regA[31] == imm_sx[31]) && (add_ri[31] != regA[31]);
   assign sub_ovf  = (regA[31] != regB[31])   && (sub_rr[31] != regA[31]);
   assign slt_rr   = $signed(regA) < $signed(regB);
   assign sltu_rr  = regA < regB;
   assign slt_ri   = $signed(regA) < $signed(imm_sx);
   assign sltu_ri  = regA < imm_sx;

`ifdef ALU_SHIFT_EN
   logic [4:0] shamt;
   logic [4:0] vamt;
   assign shamt = instruction[10:6];
   assign vamt  = regB[4:0];
`endif

   logic [31:0] res_d;
   logic        zf_d;
   logic        nf_d;
   logic        of_d;

   always_comb begin
      res_d = '0;
      zf_d  = 1'b0;
      nf_d  = 1'b0;
      of_d  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADD:  begin res_d = add_rr; of_d = add_ovf; end
               F_ADDU: res_d = add_rr;
               F_SUB:  begin res_d = sub_rr; of_d = sub_ovf; end
               F_SUBU: res_d = sub_rr;
               F_AND:  res_d = regA & regB;
               F_OR:   res_d = regA | regB;
               F_XOR:  res_d = regA ^ regB;
               F_NOR:  res_d = ~(regA | regB);
               F_SLT:  begin res_d = {31'b0, slt_rr};  nf_d = slt_rr;  end
               F_SLTU: begin res_d = {31'b0, sltu_rr}; nf_d = sltu_rr; end
`ifdef ALU_SHIFT_EN
               F_SLL:  res_d = regA << shamt;
               F_SRL:  res_d = regA >> shamt;
               F_SRA:  res_d = $unsigned($signed(regA) >>> shamt);
               F_SLLV: res_d = regA << vamt;
               F_SRLV: res_d = regA >> vamt;
               F_SRAV: res_d = $unsigned($signed(regA) >>> vamt);
`endif
               default: ;
            endcase
         end
         OP_ADDI:  begin res_d = add_ri; of_d = addi_ovf; end
         OP_ADDIU: res_d = add_ri;
         OP_ANDI:  res_d = regA & imm_zx;
         OP_ORI:   res_d = regA | imm_zx;
         OP_XORI:  res_d = regA ^ imm_zx;
         OP_SLTI:  begin res_d = {31'b0, slt_ri};  nf_d = slt_ri;  end
         OP_SLTIU: begin res_d = {31'b0, sltu_ri}; nf_d = sltu_ri; end
         // Branch compare: the difference is reported, equality drives the zero flag.
         OP_BEQ, OP_BNE: begin
            res_d = sub_rr;
            zf_d  = (regA == regB);
         end
         OP_LW, OP_SW: res_d = add_ri;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         flags  <= 3'b000;
      end else begin
         result <= res_d;
         flags  <= {zf_d, nf_d, of_d};
      end
   end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed table-driven bench for alu, with reset sequences
// Shift expectations follow ALU_SHIFT_EN.
module tb_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] regA;
   logic [31:0] regB;
   logic [31:0] result;
   logic [2:0]  flags;

   int checks = 0;
   int errors = 0;

`ifdef ALU_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   alu dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .regA        (regA),
      .regB        (regB),
      .result      (result),
      .flags       (flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] rt(input logic [5:0] funct, input logic [4:0] sh);
      return {6'b000000, 5'd1, 5'd2, 5'd3, sh, funct};
   endfunction

   function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
      return {op, 5'd1, 5'd2, imm};
   endfunction

   function automatic void add(input string n, input logic [31:0] ins, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] r, input logic [2:0] f);
      vec_t v;
      v.name = n; v.instr = ins; v.a = a; v.b = b; v.res = r; v.flg = f;
      vecs.push_back(v);
   endfunction

   function automatic void add_sh(input string n, input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] r);
      add(n, ins, a, b, SHIFT_EN ? r : 32'h0, 3'b000);
   endfunction

   task automatic check(input string n, input logic [31:0] exp_r, input logic [2:0] exp_f);
      checks++;
      if (result !== exp_r || flags !== exp_f) begin
         errors++;
         $display("FAIL %s: got result=%h flags=%b, expected result=%h flags=%b",
                  n, result, flags, exp_r, exp_f);
      end
   endtask

   task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      instruction = ins;
      regA        = a;
      regB        = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      add("add_ovf",    rt(6'b100000, 5'd0), 32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b001);
      add("addi_ovf",   it(6'b001000, 16'h0001), 32'h7FFFFFFF, 32'h0,    32'h80000000, 3'b001);
      add("addiu_neg",  it(6'b001001, 16'hFFFF), 32'h7FFFFFFF, 32'h0,    32'h7FFFFFFE, 3'b000);
      add("sub_neg",    rt(6'b100010, 5'd0), -32'sd30, -32'sd31,         32'h1,        3'b000);
      add("beq_eq",     it(6'b000100, 16'h0000), 32'd10, 32'd10,         32'h0,        3'b100);
      add("bne_ne",     it(6'b000101, 16'h0000), 32'd10, 32'd20,         32'hFFFFFFF6, 3'b000);
      add("bne_eq",     it(6'b000101, 16'h0000), 32'd7, 32'd7,           32'h0,        3'b100);
      add("slt_lt",     rt(6'b101010, 5'd0), 32'd10, 32'd20,             32'h1,        3'b010);
      add("slt_neg",    rt(6'b101010, 5'd0), 32'd1, 32'hFFFFFFFF,        32'h0,        3'b000);
      add("sltu_lt",    rt(6'b101011, 5'd0), 32'd1, 32'hFFFFFFFF,        32'h1,        3'b010);
      add("sltiu_ge",   it(6'b001011, 16'h0002), 32'd20, 32'h0,          32'h0,        3'b000);
      add("sltiu_sx",   it(6'b001011, 16'hFFFF), 32'd5, 32'h0,           32'h1,        3'b010);
      add("slti_neg",   it(6'b001010, 16'hFFFF), 32'd5, 32'h0,           32'h0,        3'b000);
      add("andi",       it(6'b001100, 16'h000C), 32'hC, 32'h0,           32'hC,        3'b000);
      add("ori_zx",     it(6'b001101, 16'h8001), 32'hF0000000, 32'h0,    32'hF0008001, 3'b000);
      add("xori_zx",    it(6'b001110, 16'hFFFF), 32'hFFFFFFFF, 32'h0,    32'hFFFF0000, 3'b000);
      add("nor",        rt(6'b100111, 5'd0), 32'hC, 32'hA,               32'hFFFFFFF1, 3'b000);
      add("and",        rt(6'b100100, 5'd0), 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 3'b000);
      add("or",         rt(6'b100101, 5'd0), 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 3'b000);
      add("xor",        rt(6'b100110, 5'd0), 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 3'b000);
      add("addu_wrap",  rt(6'b100001, 5'd0), 32'h7FFFFFFF, 32'h1,        32'h80000000, 3'b000);
      add("sub_ovf",    rt(6'b100010, 5'd0), 32'h80000000, 32'h1,        32'h7FFFFFFF, 3'b001);
      add("subu_wrap",  rt(6'b100011, 5'd0), 32'h80000000, 32'h1,        32'h7FFFFFFF, 3'b000);
      add("addi_novf",  it(6'b001000, 16'hFFFF), 32'h80000000, 32'h0,    32'h7FFFFFFF, 3'b001);
      add("lw_addr",    it(6'b100011, 16'hFFFC), 32'h1000, 32'h0,        32'h00000FFC, 3'b000);
      add("sw_noflag",  it(6'b101011, 16'h0001), 32'h7FFFFFFF, 32'h0,    32'h80000000, 3'b000);
      add("bad_funct",  rt(6'b111111, 5'd0), 32'h12345678, 32'h1,        32'h0,        3'b000);
      add("bad_opcode", it(6'b111111, 16'h1234), 32'h12345678, 32'h1,    32'h0,        3'b000);
      add_sh("sra",     rt(6'b000011, 5'd10), 32'hF0000000, 32'h0,       32'hFFFC0000);
      add_sh("sll",     rt(6'b000000, 5'd10), 32'd5, 32'h0,              32'h00001400);
      add_sh("srlv",    rt(6'b000110, 5'd0), 32'd1024, 32'd2,            32'd256);
      add_sh("srl31",   rt(6'b000010, 5'd31), 32'h80000000, 32'h0,       32'h1);
      add_sh("sllv_msk",rt(6'b000100, 5'd0), 32'd3, 32'h21,              32'd6);
      add_sh("srav0",   rt(6'b000111, 5'd0), 32'h80000000, 32'h0,        32'h80000000);
      add_sh("sra0",    rt(6'b000011, 5'd0), 32'h00001234, 32'h0,        32'h00001234);

      reset       = 1'b1;
      instruction = rt(6'b100000, 5'd0);
      regA        = 32'h7FFFFFFF;
      regB        = 32'h1;
      @(posedge clk);
      #1;
      check("reset_state", 32'h0, 3'b000);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         apply(vecs[i].instr, vecs[i].a, vecs[i].b);
         check(vecs[i].name, vecs[i].res, vecs[i].flg);
      end

      // Reset overriding a live ADD, then recovery one edge after release.
      apply(rt(6'b100000, 5'd0), 32'h7FFFFFFF, 32'h1);
      check("pre_reset_add", 32'h80000000, 3'b001);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_override", 32'h0, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      instruction = rt(6'b100000, 5'd0);
      regA = 32'd100;
      regB = 32'd23;
      @(posedge clk);
      #1;
      check("post_reset_add", 32'd123, 3'b000);
      apply(it(6'b000100, 16'h0000), 32'd5, 32'd5);
      check("post_reset_beq", 32'h0, 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
